name_column_sequencer: RTL

NAME_COLUMN_SEQUENCER -- requirements
Module: name_column_sequencer

---
 rtl/name_column_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/name_column_sequencer.sv
// Column sequencer for a 6-row glyph display.
// A 16-slot message buffer is written while idle. On start, each character is
// shown as four glyph columns and one blank separator column. Each column is
// held for COL_CYCLES cycles, counting only cycles where col_ready is high.
module name_column_sequencer #(
  parameter int unsigned COL_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [2:0] wr_char,
  input  logic [4:0] msg_len,
  input  logic       start,
  input  logic       loop_en,
  input  logic       col_ready,
  output logic [5:0] a,
  output logic       col_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

  localparam logic [7:0] LAST = 8'(COL_CYCLES - 1);

  state_t     state, state_n;
  logic [2:0] mem [16];
  logic [4:0] len, len_n;
  logic [3:0] chr, chr_n;
  logic [2:0] col, col_n;
  logic [7:0] cnt, cnt_n;
  logic [5:0] a_n;

  // Glyph ROM: column 4 is the blank separator.
  function automatic logic [5:0] glyph_col(input logic [2:0] code, input logic [2:0] c);
    logic [5:0] v;
    v = '0;
    if (c != 3'd4) begin
      case ({code, c[1:0]})
        5'b000_00: v = 6'h3F;  5'b000_01: v = 6'h21;  5'b000_10: v = 6'h21;  5'b000_11: v = 6'h1E;
        5'b001_00: v = 6'h3F;  5'b001_01: v = 6'h09;  5'b001_10: v = 6'h09;  5'b001_11: v = 6'h3F;
        5'b010_00: v = 6'h37;  5'b010_01: v = 6'h25;  5'b010_10: v = 6'h25;  5'b010_11: v = 6'h3D;
        5'b011_00: v = 6'h3F;  5'b011_01: v = 6'h20;  5'b011_10: v = 6'h20;  5'b011_11: v = 6'h3F;
        5'b100_00: v = 6'h3F;  5'b100_01: v = 6'h04;  5'b100_10: v = 6'h0A;  5'b100_11: v = 6'h31;
        5'b101_00: v = 6'h3F;  5'b101_01: v = 6'h21;  5'b101_10: v = 6'h21;  5'b101_11: v = 6'h3F;
        default:   v = '0;
      endcase
    end
    return v;
  endfunction

  // Next state, position and the registered column value.
  // a is computed from the next position so it is valid on the first SHOW cycle.
  always_comb begin
    state_n = state;
    len_n   = len;
    chr_n   = chr;
    col_n   = col;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (start && (msg_len != 5'd0)) begin
          state_n = SHOW;
          len_n   = (msg_len > 5'd16) ? 5'd16 : msg_len;
          chr_n   = '0;
          col_n   = '0;
          cnt_n   = '0;
        end
      end
      SHOW: begin
        if (col_ready) begin
          if (cnt == LAST) begin
            cnt_n = '0;
            if (col == 3'd4) begin
              col_n = '0;
              if ({1'b0, chr} == (len - 5'd1)) begin
                chr_n = '0;
                if (!loop_en) state_n = DONE;
              end else begin
                chr_n = chr + 4'd1;
              end
            end else begin
              col_n = col + 3'd1;
            end
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    a_n = (state_n == SHOW) ? glyph_col(mem[chr_n], col_n) : '0;
  end

  // State, position and message buffer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      len   <= '0;
      chr   <= '0;
      col   <= '0;
      cnt   <= '0;
      a     <= '0;
      for (int unsigned i = 0; i < 16; i++) mem[i] <= 3'd7;
    end else begin
      state <= state_n;
      len   <= len_n;
      chr   <= chr_n;
      col   <= col_n;
      cnt   <= cnt_n;
      a     <= a_n;
      if (wr_en && (state == IDLE)) mem[wr_addr] <= wr_char;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    col_valid = (state == SHOW);
    busy      = (state == SHOW);
    done      = (state == DONE);
  end

endmodule
